// File: rtl/id_stage.sv
// RV32I instruction decode stage: field decode, immediate generation, WB bypass,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
    parameter int PC_WIDTH   = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_flush,
    input  logic                  id2ex_stall,
    input  logic                  if2id_valid,
    input  logic [PC_WIDTH-1:0]   if2id_pc,
    input  logic [31:0]           if2id_instruction,
    output logic                  if2id_stall,
    output logic [4:0]            rf_rs1_addr,
    output logic [4:0]            rf_rs2_addr,
    input  logic [DATA_WIDTH-1:0] rf_rs1_rdata,
    input  logic [DATA_WIDTH-1:0] rf_rs2_rdata,
    input  logic                  wb_reg_wen,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_wdata,
    output logic                  id2ex_valid,
    output logic [PC_WIDTH-1:0]   id2ex_pc,
    output logic [DATA_WIDTH-1:0] id2ex_rs1_data,
    output logic [DATA_WIDTH-1:0] id2ex_rs2_data,
    output logic [4:0]            id2ex_rs1_addr,
    output logic [4:0]            id2ex_rs2_addr,
    output logic [DATA_WIDTH-1:0] id2ex_imm,
    output logic [4:0]            id2ex_rd,
    output logic                  id2ex_reg_wen,
    output logic [3:0]            id2ex_alu_op,
    output logic                  id2ex_alu_src1_pc,
    output logic                  id2ex_alu_src2_imm,
    output logic                  id2ex_mem_read,
    output logic                  id2ex_mem_write,
    output logic [2:0]            id2ex_funct3,
    output logic                  id2ex_branch,
    output logic                  id2ex_jal,
    output logic                  id2ex_jalr,
    output logic                  id2ex_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = if2id_instruction[6:0];
    assign rd     = if2id_instruction[11:7];
    assign funct3 = if2id_instruction[14:12];
    assign rs1    = if2id_instruction[19:15];
    assign rs2    = if2id_instruction[24:20];
    assign funct7 = if2id_instruction[31:25];

    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{if2id_instruction[31]}}, if2id_instruction[31:20]};
    assign imm_s = {{20{if2id_instruction[31]}}, if2id_instruction[31:25], if2id_instruction[11:7]};
    assign imm_b = {{19{if2id_instruction[31]}}, if2id_instruction[31], if2id_instruction[7],
                    if2id_instruction[30:25], if2id_instruction[11:8], 1'b0};
    assign imm_u = {if2id_instruction[31:12], 12'b0};
    assign imm_j = {{11{if2id_instruction[31]}}, if2id_instruction[31], if2id_instruction[19:12],
                    if2id_instruction[20], if2id_instruction[30:21], 1'b0};

    logic [31:0]           dec_imm32;
    logic [DATA_WIDTH-1:0] dec_imm;
    alu_op_t               dec_alu_op;
    logic                  dec_src1_pc;
    logic                  dec_src2_imm;
    logic                  dec_mem_read;
    logic                  dec_mem_write;
    logic                  dec_branch;
    logic                  dec_jal;
    logic                  dec_jalr;
    logic                  dec_wen;
    logic                  dec_illegal;
    logic                  rs1_used;
    logic                  rs2_used;

    // Opcode/funct decode; any unsupported encoding collapses to a NOP flagged illegal.
    always_comb begin
        dec_imm32     = imm_i;
        dec_alu_op    = ALU_ADD;
        dec_src1_pc   = 1'b0;
        dec_src2_imm  = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_jal       = 1'b0;
        dec_jalr      = 1'b0;
        dec_wen       = 1'b0;
        dec_illegal   = 1'b0;
        rs1_used      = 1'b1;
        rs2_used      = 1'b0;

        case (opcode)
            OP_LUI: begin
                dec_imm32    = imm_u;
                dec_alu_op   = ALU_PASS_B;
                dec_src2_imm = 1'b1;
                dec_wen      = 1'b1;
                rs1_used     = 1'b0;
            end
            OP_AUIPC: begin
                dec_imm32    = imm_u;
                dec_src1_pc  = 1'b1;
                dec_src2_imm = 1'b1;
                dec_wen      = 1'b1;
                rs1_used     = 1'b0;
            end
            OP_JAL: begin
                dec_imm32   = imm_j;
                dec_jal     = 1'b1;
                dec_src1_pc = 1'b1;
                dec_wen     = 1'b1;
                rs1_used    = 1'b0;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    dec_jalr    = 1'b1;
                    dec_src1_pc = 1'b1;
                    dec_wen     = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                dec_imm32  = imm_b;
                rs2_used   = 1'b1;
                dec_alu_op = ALU_SUB;
                if (funct3 == 3'b010 || funct3 == 3'b011) dec_illegal = 1'b1;
                else                                       dec_branch  = 1'b1;
            end
            OP_LOAD: begin
                case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
                        dec_mem_read = 1'b1;
                        dec_src2_imm = 1'b1;
                        dec_wen      = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                dec_imm32 = imm_s;
                rs2_used  = 1'b1;
                case (funct3)
                    3'b000, 3'b001, 3'b010: begin
                        dec_mem_write = 1'b1;
                        dec_src2_imm  = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec_src2_imm = 1'b1;
                dec_wen      = 1'b1;
                case (funct3)
                    3'b000: dec_alu_op = ALU_ADD;
                    3'b010: dec_alu_op = ALU_SLT;
                    3'b011: dec_alu_op = ALU_SLTU;
                    3'b100: dec_alu_op = ALU_XOR;
                    3'b110: dec_alu_op = ALU_OR;
                    3'b111: dec_alu_op = ALU_AND;
                    3'b001: begin
                        if (funct7 == F7_BASE) dec_alu_op  = ALU_SLL;
                        else                   dec_illegal = 1'b1;
                    end
                    default: begin
                        if (funct7 == F7_BASE)     dec_alu_op  = ALU_SRL;
                        else if (funct7 == F7_ALT) dec_alu_op  = ALU_SRA;
                        else                       dec_illegal = 1'b1;
                    end
                endcase
            end
            OP_REG: begin
                rs2_used = 1'b1;
                dec_wen  = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: dec_alu_op  = ALU_ADD;
                    {F7_ALT,  3'b000}: dec_alu_op  = ALU_SUB;
                    {F7_BASE, 3'b001}: dec_alu_op  = ALU_SLL;
                    {F7_BASE, 3'b010}: dec_alu_op  = ALU_SLT;
                    {F7_BASE, 3'b011}: dec_alu_op  = ALU_SLTU;
                    {F7_BASE, 3'b100}: dec_alu_op  = ALU_XOR;
                    {F7_BASE, 3'b101}: dec_alu_op  = ALU_SRL;
                    {F7_ALT,  3'b101}: dec_alu_op  = ALU_SRA;
                    {F7_BASE, 3'b110}: dec_alu_op  = ALU_OR;
                    {F7_BASE, 3'b111}: dec_alu_op  = ALU_AND;
                    default:           dec_illegal = 1'b1;
                endcase
            end
            OP_FENCE: begin
            end
            OP_SYSTEM: begin
                if (funct3 != 3'b000) dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase

        if (dec_illegal) begin
            dec_alu_op    = ALU_ADD;
            dec_src1_pc   = 1'b0;
            dec_src2_imm  = 1'b0;
            dec_mem_read  = 1'b0;
            dec_mem_write = 1'b0;
            dec_branch    = 1'b0;
            dec_jal       = 1'b0;
            dec_jalr      = 1'b0;
            dec_wen       = 1'b0;
        end
    end

    assign dec_imm = DATA_WIDTH'($signed(dec_imm32));

    logic dec_reg_wen;
    assign dec_reg_wen = dec_wen & (rd != 5'd0);

    // A register written by WB this cycle is not yet visible in the regfile read.
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;

    always_comb begin
        rs1_data = rf_rs1_rdata;
        rs2_data = rf_rs2_rdata;
        if (rs1 == 5'd0)                         rs1_data = '0;
        else if (wb_reg_wen && (wb_rd == rs1))   rs1_data = wb_wdata;
        if (rs2 == 5'd0)                         rs2_data = '0;
        else if (wb_reg_wen && (wb_rd == rs2))   rs2_data = wb_wdata;
    end

    logic load_use;
    assign load_use = if2id_valid & id2ex_valid & id2ex_mem_read & (id2ex_rd != 5'd0) &
                      ((rs1_used & (rs1 == id2ex_rd)) | (rs2_used & (rs2 == id2ex_rd)));

    assign if2id_stall = id2ex_stall | load_use;

    logic load_en;
    assign load_en = ~id2ex_stall & ~load_use;

    // Valid and side-effect bits: flush beats stall, stall beats the load-use bubble.
    always_ff @(posedge clk) begin
        if (rst || id_flush || (!id2ex_stall && load_use)) begin
            id2ex_valid     <= 1'b0;
            id2ex_reg_wen   <= 1'b0;
            id2ex_mem_read  <= 1'b0;
            id2ex_mem_write <= 1'b0;
            id2ex_branch    <= 1'b0;
            id2ex_jal       <= 1'b0;
            id2ex_jalr      <= 1'b0;
            id2ex_illegal   <= 1'b0;
        end else if (!id2ex_stall) begin
            id2ex_valid     <= if2id_valid;
            id2ex_reg_wen   <= if2id_valid & dec_reg_wen;
            id2ex_mem_read  <= if2id_valid & dec_mem_read;
            id2ex_mem_write <= if2id_valid & dec_mem_write;
            id2ex_branch    <= if2id_valid & dec_branch;
            id2ex_jal       <= if2id_valid & dec_jal;
            id2ex_jalr      <= if2id_valid & dec_jalr;
            id2ex_illegal   <= if2id_valid & dec_illegal;
        end
    end

    // Payload fields are only meaningful alongside valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            id2ex_pc           <= if2id_pc;
            id2ex_rs1_data     <= rs1_data;
            id2ex_rs2_data     <= rs2_data;
            id2ex_rs1_addr     <= rs1;
            id2ex_rs2_addr     <= rs2;
            id2ex_imm          <= dec_imm;
            id2ex_rd           <= rd;
            id2ex_alu_op       <= dec_alu_op;
            id2ex_alu_src1_pc  <= dec_src1_pc;
            id2ex_alu_src2_imm <= dec_src2_imm;
            id2ex_funct3       <= funct3;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: decode, bypass, load-use bubble,
// flush, EX back-pressure, illegal encodings and mid-stream reset.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        id_flush;
    logic        id2ex_stall;
    logic        if2id_valid;
    logic [31:0] if2id_pc;
    logic [31:0] if2id_instruction;
    logic        if2id_stall;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [31:0] rf_rs1_rdata;
    logic [31:0] rf_rs2_rdata;
    logic        wb_reg_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic        id2ex_valid;
    logic [31:0] id2ex_pc;
    logic [31:0] id2ex_rs1_data;
    logic [31:0] id2ex_rs2_data;
    logic [4:0]  id2ex_rs1_addr;
    logic [4:0]  id2ex_rs2_addr;
    logic [31:0] id2ex_imm;
    logic [4:0]  id2ex_rd;
    logic        id2ex_reg_wen;
    logic [3:0]  id2ex_alu_op;
    logic        id2ex_alu_src1_pc;
    logic        id2ex_alu_src2_imm;
    logic        id2ex_mem_read;
    logic        id2ex_mem_write;
    logic [2:0]  id2ex_funct3;
    logic        id2ex_branch;
    logic        id2ex_jal;
    logic        id2ex_jalr;
    logic        id2ex_illegal;

    int compare_count;
    int mismatch_count;

    id_stage #(.PC_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_flush          (id_flush),
        .id2ex_stall       (id2ex_stall),
        .if2id_valid       (if2id_valid),
        .if2id_pc          (if2id_pc),
        .if2id_instruction (if2id_instruction),
        .if2id_stall       (if2id_stall),
        .rf_rs1_addr       (rf_rs1_addr),
        .rf_rs2_addr       (rf_rs2_addr),
        .rf_rs1_rdata      (rf_rs1_rdata),
        .rf_rs2_rdata      (rf_rs2_rdata),
        .wb_reg_wen        (wb_reg_wen),
        .wb_rd             (wb_rd),
        .wb_wdata          (wb_wdata),
        .id2ex_valid       (id2ex_valid),
        .id2ex_pc          (id2ex_pc),
        .id2ex_rs1_data    (id2ex_rs1_data),
        .id2ex_rs2_data    (id2ex_rs2_data),
        .id2ex_rs1_addr    (id2ex_rs1_addr),
        .id2ex_rs2_addr    (id2ex_rs2_addr),
        .id2ex_imm         (id2ex_imm),
        .id2ex_rd          (id2ex_rd),
        .id2ex_reg_wen     (id2ex_reg_wen),
        .id2ex_alu_op      (id2ex_alu_op),
        .id2ex_alu_src1_pc (id2ex_alu_src1_pc),
        .id2ex_alu_src2_imm(id2ex_alu_src2_imm),
        .id2ex_mem_read    (id2ex_mem_read),
        .id2ex_mem_write   (id2ex_mem_write),
        .id2ex_funct3      (id2ex_funct3),
        .id2ex_branch      (id2ex_branch),
        .id2ex_jal         (id2ex_jal),
        .id2ex_jalr        (id2ex_jalr),
        .id2ex_illegal     (id2ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Present an instruction to ID and let the combinational decode settle.
    task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
        if2id_valid       = valid;
        if2id_instruction = instr;
        if2id_pc          = pc;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compare_count  = 0;
        mismatch_count = 0;
        rst = 1'b1;
        id_flush = 1'b0;
        id2ex_stall = 1'b0;
        if2id_valid = 1'b0;
        if2id_pc = '0;
        if2id_instruction = 32'h0000_0013;
        rf_rs1_rdata = '0;
        rf_rs2_rdata = '0;
        wb_reg_wen = 1'b0;
        wb_rd = '0;
        wb_wdata = '0;
        step();
        step();
        rst = 1'b0;

        checkOutput("reset_ctrl", {id2ex_valid, id2ex_reg_wen, id2ex_mem_read, id2ex_mem_write,
                                   id2ex_branch, id2ex_jal, id2ex_jalr, id2ex_illegal}, 32'h0);

        // ADDI x1,x0,5 with junk on the read/WB ports: x0 must still read as zero.
        rf_rs1_rdata = 32'h1234;
        wb_reg_wen = 1'b1; wb_rd = 5'd0; wb_wdata = 32'hBEEF;
        applyStimulus(1'b1, 32'h0050_0093, 32'h100);
        step();
        checkOutput("addi_valid", id2ex_valid, 1);
        checkOutput("addi_rd", id2ex_rd, 1);
        checkOutput("addi_imm", id2ex_imm, 5);
        checkOutput("addi_alu_op", id2ex_alu_op, 0);
        checkOutput("addi_src2_imm", id2ex_alu_src2_imm, 1);
        checkOutput("addi_reg_wen", id2ex_reg_wen, 1);
        checkOutput("addi_rs1_x0", id2ex_rs1_data, 0);
        checkOutput("addi_pc", id2ex_pc, 32'h100);
        wb_reg_wen = 1'b0; rf_rs1_rdata = '0;

        // LW x2,0(x1) followed by ADD x3,x2,x2: one bubble, then ADD issues.
        applyStimulus(1'b1, 32'h0000_A103, 32'h104);
        step();
        checkOutput("lw_mem_read", id2ex_mem_read, 1);
        checkOutput("lw_rd", id2ex_rd, 2);
        applyStimulus(1'b1, 32'h0021_01B3, 32'h108);
        checkOutput("lu_stall_on", if2id_stall, 1);
        step();
        checkOutput("lu_bubble_valid", id2ex_valid, 0);
        checkOutput("lu_bubble_wen", id2ex_reg_wen, 0);
        checkOutput("lu_bubble_mrd", id2ex_mem_read, 0);
        checkOutput("lu_stall_off", if2id_stall, 0);
        step();
        checkOutput("add_valid", id2ex_valid, 1);
        checkOutput("add_rd", id2ex_rd, 3);
        checkOutput("add_pc", id2ex_pc, 32'h108);
        checkOutput("add_src2_imm", id2ex_alu_src2_imm, 0);
        checkOutput("add_rs2_addr", id2ex_rs2_addr, 2);

        // WB bypass into rs1 of ADD x5,x4,x0.
        wb_reg_wen = 1'b1; wb_rd = 5'd4; wb_wdata = 32'hDEAD;
        applyStimulus(1'b1, 32'h0002_02B3, 32'h10C);
        checkOutput("rf_rs1_addr", rf_rs1_addr, 4);
        step();
        checkOutput("byp_rs1", id2ex_rs1_data, 32'hDEAD);
        checkOutput("byp_rs2", id2ex_rs2_data, 0);
        wb_reg_wen = 1'b0; rf_rs1_rdata = 32'h55;
        step();
        checkOutput("nobyp_rs1", id2ex_rs1_data, 32'h55);
        rf_rs1_rdata = '0;

        // BEQ x0,x0,-8, then the same with a flush from EX.
        applyStimulus(1'b1, 32'hFE00_0CE3, 32'h110);
        step();
        checkOutput("beq_imm", id2ex_imm, 32'hFFFF_FFF8);
        checkOutput("beq_branch", id2ex_branch, 1);
        checkOutput("beq_reg_wen", id2ex_reg_wen, 0);
        id_flush = 1'b1;
        step();
        checkOutput("flush_valid", id2ex_valid, 0);
        checkOutput("flush_branch", id2ex_branch, 0);
        id_flush = 1'b0;

        // EX back-pressure: ADDI held in EX while SW waits in ID for three cycles.
        applyStimulus(1'b1, 32'h0050_0093, 32'h120);
        step();
        id2ex_stall = 1'b1;
        applyStimulus(1'b1, 32'h0050_A423, 32'h124);
        checkOutput("stall_if2id", if2id_stall, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("stall_hold_imm", id2ex_imm, 5);
            checkOutput("stall_hold_pc", id2ex_pc, 32'h120);
            checkOutput("stall_hold_valid", id2ex_valid, 1);
            checkOutput("stall_hold_mwr", id2ex_mem_write, 0);
        end
        id2ex_stall = 1'b0;
        step();
        checkOutput("sw_mem_write", id2ex_mem_write, 1);
        checkOutput("sw_imm", id2ex_imm, 8);
        checkOutput("sw_reg_wen", id2ex_reg_wen, 0);
        checkOutput("sw_rs2_addr", id2ex_rs2_addr, 5);
        applyStimulus(1'b0, 32'h0050_A423, 32'h124);
        step();
        checkOutput("sw_once_valid", id2ex_valid, 0);
        checkOutput("sw_once_mwr", id2ex_mem_write, 0);

        // ADDI x0,x0,1 must not write.
        applyStimulus(1'b1, 32'h0010_0013, 32'h128);
        step();
        checkOutput("x0_valid", id2ex_valid, 1);
        checkOutput("x0_reg_wen", id2ex_reg_wen, 0);

        // Unknown opcode 0x7F with rd=1.
        applyStimulus(1'b1, 32'h0000_00FF, 32'h12C);
        step();
        checkOutput("ill_flag", id2ex_illegal, 1);
        checkOutput("ill_valid", id2ex_valid, 1);
        checkOutput("ill_mem_write", id2ex_mem_write, 0);
        checkOutput("ill_reg_wen", id2ex_reg_wen, 0);

        // ECALL is a legal NOP.
        applyStimulus(1'b1, 32'h0000_0073, 32'h130);
        step();
        checkOutput("ecall_illegal", id2ex_illegal, 0);
        checkOutput("ecall_reg_wen", id2ex_reg_wen, 0);

        // LUI x6,0x12345.
        applyStimulus(1'b1, 32'h1234_5337, 32'h134);
        step();
        checkOutput("lui_imm", id2ex_imm, 32'h1234_5000);
        checkOutput("lui_alu_op", id2ex_alu_op, 10);
        checkOutput("lui_reg_wen", id2ex_reg_wen, 1);

        // SUB x7,x1,x2.
        applyStimulus(1'b1, 32'h4020_83B3, 32'h138);
        step();
        checkOutput("sub_alu_op", id2ex_alu_op, 1);
        checkOutput("sub_rd", id2ex_rd, 7);

        // Synchronous reset in the middle of a valid stream, then recovery.
        applyStimulus(1'b1, 32'h0050_0093, 32'h13C);
        rst = 1'b1;
        step();
        checkOutput("rst_mid_valid", id2ex_valid, 0);
        checkOutput("rst_mid_wen", id2ex_reg_wen, 0);
        rst = 1'b0;
        step();
        checkOutput("post_rst_valid", id2ex_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
